instruction_fetch: RTL and testbench

//  Program-memory side of the control unit's fetch interface. Accepts a program as a byte stream from the host
//  (valid/ready) and holds the control unit in reset until the load completes. It then serves one 16-bit

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_ram.sv | 29 ++
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and widths for the instruction memory fetch block
package imem_pkg;

  typedef enum logic [1:0] {LOAD, PRIME, RUN, ERR} imem_state_t;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  function automatic logic word_parity(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port program RAM, synchronous write and read, read-old-data, no reset
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both ports update with non-blocking assignments, so a same-address read returns the old word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - byte-stream program loader and 1-cycle instruction fetch for the control unit
// Optional fetch parity check enabled by defining IMEM_PARITY_EN.
module instruction_fetch
  import imem_pkg::*;
#(
  parameter int PC_LENGTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [BYTE_W-1:0]    load_data,
  input  logic                 load_last,
  input  logic [PC_LENGTH-1:0] next_program_counter,
  output logic [WORD_W-1:0]    instruction,
  output logic                 core_rst,
  output logic                 load_error,
  output logic                 parity_error
);

  localparam int ADDR_W = PC_LENGTH - 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = WORD_W + 1;
`else
  localparam int MEM_W = WORD_W;
`endif

  imem_state_t          state;
  imem_state_t          state_nx;
  logic [PC_LENGTH-1:0] byte_cnt;
  logic [BYTE_W-1:0]    lo_byte;
  logic                 xfer;
  logic                 odd_byte;
  logic                 last_slot;
  logic [WORD_W-1:0]    wr_word;
  logic [MEM_W-1:0]     wr_data;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [MEM_W-1:0]     rd_data;
  logic                 unused_pc_bit0;

  assign unused_pc_bit0 = next_program_counter[0];

  assign xfer      = load_valid && load_ready;
  assign odd_byte  = byte_cnt[0];
  assign last_slot = &byte_cnt;
  assign wr_word   = {load_data, lo_byte};
  assign wr_en     = xfer && odd_byte;

`ifdef IMEM_PARITY_EN
  assign wr_data = {word_parity(wr_word), wr_word};
`else
  assign wr_data = wr_word;
`endif

  // PRIME reads word 0 so the first RUN cycle already presents the reset-vector instruction
  assign rd_en   = (state == PRIME) || (state == RUN);
  assign rd_addr = (state == RUN) ? next_program_counter[PC_LENGTH-1:1] : '0;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (MEM_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (byte_cnt[PC_LENGTH-1:1]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        if (xfer) begin
          if (load_last) begin
            state_nx = odd_byte ? PRIME : ERR;
          end else if (last_slot) begin
            state_nx = ERR;
          end
        end
      end
      PRIME:   state_nx = RUN;
      RUN:     state_nx = RUN;
      ERR:     state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      byte_cnt   <= '0;
      lo_byte    <= '0;
      core_rst   <= 1'b1;
      load_error <= 1'b0;
    end else begin
      state      <= state_nx;
      core_rst   <= (state_nx != RUN);
      load_error <= (state_nx == ERR);
      if (xfer) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (!odd_byte) begin
          lo_byte <= load_data;
        end
      end
    end
  end

  // rd_data is the fetch register; outside RUN the control unit sees a zero instruction
  assign instruction = (state == RUN) ? rd_data[WORD_W-1:0] : '0;

`ifdef IMEM_PARITY_EN
  logic fetch_bad;
  logic parity_sticky;

  assign fetch_bad = (state == RUN) && (rd_data[WORD_W] != word_parity(rd_data[WORD_W-1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_sticky <= 1'b0;
    end else if (fetch_bad) begin
      parity_sticky <= 1'b1;
    end
  end

  assign parity_error = parity_sticky || fetch_bad;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch (PC_LENGTH 12 and 4 instances)
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_last;
  logic [11:0] npc;
  logic [15:0] instruction;
  logic        core_rst;
  logic        load_error;
  logic        parity_error;

  logic        v4;
  logic        ready4;
  logic [7:0]  d4;
  logic        l4;
  logic [3:0]  npc4;
  logic [15:0] inst4;
  logic        crst4;
  logic        err4;
  logic        perr4;

  always #5 clk = ~clk;

  instruction_fetch #(.PC_LENGTH(12)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .load_valid           (load_valid),
    .load_ready           (load_ready),
    .load_data            (load_data),
    .load_last            (load_last),
    .next_program_counter (npc),
    .instruction          (instruction),
    .core_rst             (core_rst),
    .load_error           (load_error),
    .parity_error         (parity_error)
  );

  instruction_fetch #(.PC_LENGTH(4)) dut4 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .load_valid           (v4),
    .load_ready           (ready4),
    .load_data            (d4),
    .load_last            (l4),
    .next_program_counter (npc4),
    .instruction          (inst4),
    .core_rst             (crst4),
    .load_error           (err4),
    .parity_error         (perr4)
  );

  localparam int S_INST = 0, S_CRST = 1, S_RDY = 2, S_LERR = 3, S_PERR = 4, S_CNT = 5,
                 S_ERR4 = 6, S_RDY4 = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] probe(input int sig);
    case (sig)
      S_INST:  return instruction;
      S_CRST:  return {15'd0, core_rst};
      S_RDY:   return {15'd0, load_ready};
      S_LERR:  return {15'd0, load_error};
      S_PERR:  return {15'd0, parity_error};
      S_CNT:   return {4'd0, dut.byte_cnt};
      S_ERR4:  return {15'd0, err4};
      S_RDY4:  return {15'd0, ready4};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Expectations pushed at negedge+1 describe the outputs after the next posedge
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = probe(e.sig);
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic want(input string n, input int s, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    load_valid = 1'b0;
    load_data  = 8'hAA;
    load_last  = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    cyc();
    idle();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input bit gap, input string tag);
    xfer(8'h34, 1'b0);
    if (gap) cyc();
    xfer(8'h12, 1'b0);
    if (gap) cyc();
    xfer(8'h78, 1'b0);
    if (gap) cyc();
    want({tag, " core_rst after last byte"}, S_CRST, 16'h1);
    want({tag, " ready in PRIME"}, S_RDY, 16'h0);
    want({tag, " inst in PRIME"}, S_INST, 16'h0000);
    xfer(8'h56, 1'b1);
    want({tag, " core_rst released"}, S_CRST, 16'h0);
    want({tag, " first inst"}, S_INST, 16'h1234);
    cyc();
  endtask

  task automatic fetch(input logic [11:0] pc, input logic [15:0] exp, input string tag);
    npc = pc;
    want(tag, S_INST, exp);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    npc  = '0;
    v4   = 1'b0;
    d4   = '0;
    l4   = 1'b0;
    npc4 = '0;
    cyc();
    want("reset inst", S_INST, 16'h0000);
    want("reset core_rst", S_CRST, 16'h1);
    want("reset ready", S_RDY, 16'h1);
    want("reset load_error", S_LERR, 16'h0);
    want("reset parity_error", S_PERR, 16'h0);
    want("reset byte_cnt", S_CNT, 16'h0);
    cyc();
    rst_n = 1'b1;

    load_prog(1'b0, "t1");

    load_valid = 1'b1;
    want("t2 ready low in RUN", S_RDY, 16'h0);
    fetch(12'd2, 16'h5678, "t2 pc2");
    fetch(12'd0, 16'h1234, "t2 pc0");
    fetch(12'd3, 16'h5678, "t2 pc3");
    idle();

    pulse_reset();
    npc = '0;
    load_prog(1'b1, "t3");
    fetch(12'd2, 16'h5678, "t3 pc2");
    fetch(12'd1, 16'h1234, "t3 pc1");

    pulse_reset();
    npc = '0;
    xfer(8'h01, 1'b0);
    xfer(8'h02, 1'b0);
    want("t4 load_error", S_LERR, 16'h1);
    want("t4 ready", S_RDY, 16'h0);
    want("t4 core_rst", S_CRST, 16'h1);
    xfer(8'h03, 1'b1);
    want("t4 load_error sticky", S_LERR, 16'h1);
    want("t4 core_rst held", S_CRST, 16'h1);
    want("t4 inst zero", S_INST, 16'h0000);
    cyc();
    pulse_reset();
    load_prog(1'b0, "t4r");
    fetch(12'd2, 16'h5678, "t4r pc2");

    pulse_reset();
    npc = '0;
    xfer(8'h11, 1'b0);
    xfer(8'h22, 1'b0);
    // Reset pulse lies between clock edges, so only an asynchronous reset can catch it
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    want("t5 abort ready", S_RDY, 16'h1);
    want("t5 abort core_rst", S_CRST, 16'h1);
    want("t5 abort byte_cnt", S_CNT, 16'h0);
    cyc();
    load_prog(1'b0, "t5r");
    fetch(12'd2, 16'h5678, "t5r pc2");

    for (int i = 0; i < 16; i++) begin
      if (i == 14) want("t5 no overflow at byte 15", S_ERR4, 16'h0);
      if (i == 15) begin
        want("t5 overflow load_error", S_ERR4, 16'h1);
        want("t5 overflow ready", S_RDY4, 16'h0);
      end
      v4 = 1'b1;
      d4 = 8'(i);
      l4 = 1'b0;
      cyc();
    end
    v4 = 1'b0;

`ifdef IMEM_PARITY_EN
    dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
    npc = 12'd2;
    want("t6 corrupted inst", S_INST, 16'h5679);
    want("t6 parity_error", S_PERR, 16'h1);
    cyc();
    npc = 12'd0;
    want("t6 parity sticky", S_PERR, 16'h1);
    want("t6 clean inst", S_INST, 16'h1234);
    cyc();
`endif

    cyc();
    cyc();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
